// File: rtl/ticket_dispenser.sv
// ticket_dispenser
//
// Back-end dispense controller for the metro ticket machine. Takes one result
// from the vending core (done pulse plus fields) and works it off through the
// printer and coin hopper, one item per req/ack handshake: first the tickets,
// then the money as greedy coins (50, 20, 10, 5, 2, 1). A failed transaction
// (refund != 0) pays the refund only and prints nothing.
//
// Parameters
//   ACK_TIMEOUT  cycles a request may stay unacknowledged before a fault
//   TO_W         width of the timeout counter; must hold ACK_TIMEOUT
//
// Ports
//   clk, rst     clock (rising edge), synchronous active-high reset
//   done         one-cycle result strobe; ticket_out/count/change/refund valid with it
//   tkt_req/tkt_dest/tkt_ack      printer handshake (one ticket per handshake)
//   coin_req/coin_code/coin_ack   hopper handshake (one coin per handshake)
//   busy         job in progress (from the cycle after acceptance up to fin)
//   fin          one-cycle pulse at job end
//   fault        sticky ack-timeout flag, cleared by rst or the next accepted job
//   overrun      one-cycle pulse after a done that arrived while not idle

module ticket_dispenser #(
    parameter int unsigned ACK_TIMEOUT = 1000,
    parameter int unsigned TO_W        = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       done,
    input  logic [1:0] ticket_out,
    input  logic [1:0] count,
    input  logic [7:0] change,
    input  logic [7:0] refund,
    output logic       tkt_req,
    output logic [1:0] tkt_dest,
    input  logic       tkt_ack,
    output logic       coin_req,
    output logic [2:0] coin_code,
    input  logic       coin_ack,
    output logic       busy,
    output logic       fin,
    output logic       fault,
    output logic       overrun
);

    typedef enum logic [2:0] {
        StIdle,
        StTktReq,
        StTktGap,
        StCoinReq,
        StCoinGap,
        StFinish
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      dest_q, dest_d;
    logic [1:0]      tkt_left_q, tkt_left_d;
    logic [7:0]      amount_q, amount_d;
    logic [TO_W-1:0] timer_q, timer_d;
    logic            fault_q, fault_d;
    logic            overrun_q, overrun_d;

    // Job decode at acceptance: a nonzero refund overrides tickets and change.
    logic [7:0] job_amount;
    logic [1:0] job_tkts;
    assign job_amount = (refund != 8'd0) ? refund : change;
    assign job_tkts   = (refund != 8'd0) ? 2'd0 : count;

    // Largest coin not exceeding the remaining amount.
    logic [2:0] pick_code;
    logic [7:0] pick_val;
    always_comb begin
        pick_code = 3'd0;
        pick_val  = 8'd0;
        if (amount_q >= 8'd50) begin
            pick_code = 3'd6;
            pick_val  = 8'd50;
        end else if (amount_q >= 8'd20) begin
            pick_code = 3'd5;
            pick_val  = 8'd20;
        end else if (amount_q >= 8'd10) begin
            pick_code = 3'd4;
            pick_val  = 8'd10;
        end else if (amount_q >= 8'd5) begin
            pick_code = 3'd3;
            pick_val  = 8'd5;
        end else if (amount_q >= 8'd2) begin
            pick_code = 3'd2;
            pick_val  = 8'd2;
        end else if (amount_q != 8'd0) begin
            pick_code = 3'd1;
            pick_val  = 8'd1;
        end
    end

    // The request is held for exactly ACK_TIMEOUT cycles before giving up.
    logic timeout_hit;
    assign timeout_hit = (timer_q == TO_W'(ACK_TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        tkt_left_d = tkt_left_q;
        amount_d   = amount_q;
        timer_d    = '0;  // every REQ state is entered from a non-REQ state
        fault_d    = fault_q;
        overrun_d  = done && (state_q != StIdle);

        tkt_req    = 1'b0;
        tkt_dest   = 2'd0;
        coin_req   = 1'b0;
        coin_code  = 3'd0;
        fin        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (done) begin
                    dest_d     = ticket_out;
                    tkt_left_d = job_tkts;
                    amount_d   = job_amount;
                    fault_d    = 1'b0;
                    if (job_tkts != 2'd0) begin
                        state_d = StTktReq;
                    end else if (job_amount != 8'd0) begin
                        state_d = StCoinReq;
                    end else begin
                        state_d = StFinish;
                    end
                end
            end

            StTktReq: begin
                tkt_req  = 1'b1;
                tkt_dest = dest_q;
                if (tkt_ack) begin
                    tkt_left_d = tkt_left_q - 2'd1;
                    state_d    = StTktGap;
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                    state_d = StFinish;
                end else begin
                    timer_d = timer_q + TO_W'(1);
                end
            end

            StTktGap: begin
                if (tkt_left_q != 2'd0) begin
                    state_d = StTktReq;
                end else if (amount_q != 8'd0) begin
                    state_d = StCoinReq;
                end else begin
                    state_d = StFinish;
                end
            end

            StCoinReq: begin
                coin_req  = 1'b1;
                coin_code = pick_code;
                if (coin_ack) begin
                    amount_d = amount_q - pick_val;
                    state_d  = StCoinGap;
                end else if (timeout_hit) begin
                    fault_d = 1'b1;
                    state_d = StFinish;
                end else begin
                    timer_d = timer_q + TO_W'(1);
                end
            end

            StCoinGap: begin
                state_d = (amount_q != 8'd0) ? StCoinReq : StFinish;
            end

            StFinish: begin
                fin     = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy    = (state_q != StIdle);
    assign fault   = fault_q;
    assign overrun = overrun_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            dest_q     <= 2'd0;
            tkt_left_q <= 2'd0;
            amount_q   <= 8'd0;
            timer_q    <= '0;
            fault_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dest_q     <= dest_d;
            tkt_left_q <= tkt_left_d;
            amount_q   <= amount_d;
            timer_q    <= timer_d;
            fault_q    <= fault_d;
            overrun_q  <= overrun_d;
        end
    end

endmodule

// File: tb/tb_ticket_dispenser.sv
// Scoreboard bench for ticket_dispenser. Stimulus pushes the expected item
// stream (tickets, coins, final fin with its fault value) computed from the
// dispensing rules; a monitor pops and compares whenever a request rises or
// fin pulses. Ack responders add random latency and spurious acks.

module tb_ticket_dispenser;

    localparam int unsigned ACK_TIMEOUT = 8;
    localparam int unsigned TO_W        = 4;

    localparam int KTKT  = 0;
    localparam int KCOIN = 1;
    localparam int KFIN  = 2;

    logic       clk;
    logic       rst;
    logic       done;
    logic [1:0] ticket_out;
    logic [1:0] count;
    logic [7:0] change;
    logic [7:0] refund;
    logic       tkt_req;
    logic [1:0] tkt_dest;
    logic       tkt_ack;
    logic       coin_req;
    logic [2:0] coin_code;
    logic       coin_ack;
    logic       busy;
    logic       fin;
    logic       fault;
    logic       overrun;

    ticket_dispenser #(
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .TO_W       (TO_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .done      (done),
        .ticket_out(ticket_out),
        .count     (count),
        .change    (change),
        .refund    (refund),
        .tkt_req   (tkt_req),
        .tkt_dest  (tkt_dest),
        .tkt_ack   (tkt_ack),
        .coin_req  (coin_req),
        .coin_code (coin_code),
        .coin_ack  (coin_ack),
        .busy      (busy),
        .fin       (fin),
        .fault     (fault),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    typedef struct {
        int kind;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    int  ack_max   = 0;
    bit  hold_tkt  = 1'b0;
    bit  hold_coin = 1'b0;
    bit  spurious  = 1'b0;

    int  first_req_cyc = -1;
    int  fin_cyc       = -1;
    int  done_cyc      = 0;
    int  n_over        = 0;
    int  n_over_exp    = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: the item stream a job should produce.
    task automatic push_job(input int dest, input int cnt, input int chg, input int rfd);
        int   denom[6];
        int   amt;
        int   n;
        ev_t  e;
        denom = '{50, 20, 10, 5, 2, 1};
        amt   = (rfd != 0) ? rfd : chg;
        n     = (rfd != 0) ? 0 : cnt;
        if (n > 0 && hold_tkt) begin
            e = '{KTKT, dest};
            exp_q.push_back(e);
            e = '{KFIN, 1};
            exp_q.push_back(e);
            return;
        end
        for (int i = 0; i < n; i++) begin
            e = '{KTKT, dest};
            exp_q.push_back(e);
        end
        for (int i = 0; i < 6; i++) begin
            while (amt >= denom[i]) begin
                e = '{KCOIN, 6 - i};
                exp_q.push_back(e);
                if (hold_coin) begin
                    e = '{KFIN, 1};
                    exp_q.push_back(e);
                    return;
                end
                amt -= denom[i];
            end
        end
        e = '{KFIN, 0};
        exp_q.push_back(e);
    endtask

    // Ack responders.
    int tkt_cnt = 0, tkt_dly = 0, coin_cnt = 0, coin_dly = 0;
    initial begin
        tkt_ack  = 1'b0;
        coin_ack = 1'b0;
        forever begin
            @(negedge clk);
            tkt_ack  = 1'b0;
            coin_ack = 1'b0;
            if (tkt_req) begin
                if (!hold_tkt && tkt_cnt >= tkt_dly) tkt_ack = 1'b1;
                tkt_cnt++;
            end else begin
                tkt_cnt = 0;
                tkt_dly = int'($urandom_range(0, ack_max));
                if (spurious && $urandom_range(0, 3) == 0) tkt_ack = 1'b1;
            end
            if (coin_req) begin
                if (!hold_coin && coin_cnt >= coin_dly) coin_ack = 1'b1;
                coin_cnt++;
            end else begin
                coin_cnt = 0;
                coin_dly = int'($urandom_range(0, ack_max));
                if (spurious && $urandom_range(0, 3) == 0) coin_ack = 1'b1;
            end
        end
    end

    task automatic pop_cmp(input int kind, input int val, input string name, output ev_t e);
        e = '{-1, -1};
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected output value %0d, nothing expected (cycle %0d)",
                     name, val, cyc);
        end else begin
            e = exp_q.pop_front();
            chk({name, " kind"}, kind, e.kind);
            chk(name, val, e.val);
        end
    endtask

    // Monitor.
    initial begin
        bit  prev_tkt, prev_coin;
        int  held_dest, held_code, req_len, last_len;
        ev_t e;
        prev_tkt  = 1'b0;
        prev_coin = 1'b0;
        held_dest = 0;
        held_code = 0;
        req_len   = 0;
        last_len  = 0;
        forever begin
            @(negedge clk);
            if (tkt_req && !prev_tkt) begin
                pop_cmp(KTKT, int'(tkt_dest), "tkt_dest", e);
                held_dest = int'(tkt_dest);
                if (first_req_cyc < 0) first_req_cyc = cyc;
                req_len = 1;
            end else if (tkt_req) begin
                chk("tkt_dest stable", int'(tkt_dest), held_dest);
                req_len++;
            end
            if (coin_req && !prev_coin) begin
                pop_cmp(KCOIN, int'(coin_code), "coin_code", e);
                held_code = int'(coin_code);
                if (first_req_cyc < 0) first_req_cyc = cyc;
                req_len = 1;
            end else if (coin_req) begin
                chk("coin_code stable", int'(coin_code), held_code);
                req_len++;
            end
            if (!tkt_req && !coin_req && (prev_tkt || prev_coin)) last_len = req_len;
            if (fin) begin
                fin_cyc = cyc;
                pop_cmp(KFIN, int'(fault), "fin fault", e);
                if (e.kind == KFIN && e.val == 1) chk("timeout req cycles", last_len, ACK_TIMEOUT);
            end
            if (overrun) n_over++;
            prev_tkt  = tkt_req;
            prev_coin = coin_req;
        end
    end

    // inj: 0 none, 1 one extra done at the first coin request, 2 random extra dones.
    task automatic run_job(input int dest, input int cnt, input int chg, input int rfd,
                           input int inj);
        bit ended;
        bit injected;
        push_job(dest, cnt, chg, rfd);
        first_req_cyc = -1;
        done_cyc      = cyc;
        ticket_out    = 2'(dest);
        count         = 2'(cnt);
        change        = 8'(chg);
        refund        = 8'(rfd);
        done          = 1'b1;
        @(negedge clk);
        #1;
        done     = 1'b0;
        ended    = 1'b0;
        injected = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (exp_q.size() == 0 && !busy) begin
                ended = 1'b1;
                break;
            end
            if (busy && ((inj == 1 && coin_req && !injected) ||
                         (inj == 2 && $urandom_range(0, 15) == 0))) begin
                ticket_out = 2'($urandom_range(0, 3));
                count      = 2'($urandom_range(0, 3));
                change     = 8'($urandom_range(0, 255));
                refund     = 8'($urandom_range(0, 255));
                done       = 1'b1;
                injected   = 1'b1;
                n_over_exp++;
            end
            @(negedge clk);
            #1;
            done = 1'b0;
        end
        chk("job completes in bound", int'(ended), 1);
        if (!ended) exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " tkt_req"}, int'(tkt_req), 0);
        chk({tag, " tkt_dest"}, int'(tkt_dest), 0);
        chk({tag, " coin_req"}, int'(coin_req), 0);
        chk({tag, " coin_code"}, int'(coin_code), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " fin"}, int'(fin), 0);
        chk({tag, " fault"}, int'(fault), 0);
        chk({tag, " overrun"}, int'(overrun), 0);
    endtask

    initial begin
        bit seen;
        rst        = 1'b1;
        done       = 1'b0;
        ticket_out = 2'd0;
        count      = 2'd0;
        change     = 8'd0;
        refund     = 8'd0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        #1;

        // Three tickets, immediate acks: 2 cycles per item.
        ack_max = 0;
        run_job(2, 3, 0, 0, 0);
        chk("done to first req cycles", first_req_cyc - done_cyc, 1);
        chk("first req to fin cycles", fin_cyc - first_req_cyc, 6);

        // One ticket then 87 in coins; refund overrides tickets and change.
        run_job(1, 1, 87, 0, 0);
        run_job(0, 3, 33, 100, 0);

        // Empty job: fin right away, no request.
        run_job(3, 0, 0, 0, 0);
        chk("empty job done to fin cycles", fin_cyc - done_cyc, 1);
        chk("empty job raised no req", first_req_cyc, -1);

        // Printer never acks.
        hold_tkt = 1'b1;
        run_job(2, 2, 0, 0, 0);
        hold_tkt = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("fault sticky while idle", int'(fault), 1);
        run_job(0, 1, 5, 0, 0);
        chk("fault cleared by next job", int'(fault), 0);

        // Hopper never acks.
        hold_coin = 1'b1;
        run_job(1, 0, 7, 0, 0);
        hold_coin = 1'b0;

        // Extra done during payout plus spurious acks.
        spurious = 1'b1;
        ack_max  = 2;
        run_job(3, 0, 87, 0, 1);
        chk("overrun count after payout", n_over, n_over_exp);
        spurious = 1'b0;

        // Reset while a coin request is pending.
        ticket_out = 2'd1;
        count      = 2'd0;
        change     = 8'd200;
        refund     = 8'd0;
        push_job(1, 0, 200, 0);
        done       = 1'b1;
        @(negedge clk);
        #1;
        done = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (coin_req) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        chk("coin_req before reset", int'(seen), 1);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        #1;
        check_all_zero("mid-job reset");
        rst = 1'b0;
        @(negedge clk);
        #1;
        run_job(3, 1, 0, 0, 0);

        // Random jobs.
        ack_max  = 3;
        spurious = 1'b1;
        for (int j = 0; j < 40; j++) begin
            int d, c, ch, rf;
            d  = int'($urandom_range(0, 3));
            c  = int'($urandom_range(0, 3));
            ch = int'($urandom_range(0, 255));
            rf = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 255)) : 0;
            run_job(d, c, ch, rf, 2);
        end
        repeat (2) @(negedge clk);
        #1;
        chk("overrun count total", n_over, n_over_exp);
        chk("scoreboard drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ticket_dispenser.md
# ticket_dispenser

Back-end dispense controller for the metro ticket machine. It consumes the vending core's result interface (`done`, `ticket_out`, `count`, `change`, `refund`) and drives the physical ticket printer and coin hopper through per-item req/ack handshakes. On a successful transaction it issues N tickets and then pays change as greedy coins. On a failed transaction it pays the refund only.

## Interface
- `ACK_TIMEOUT`, default 1000: cycles to wait for any ack before declaring a fault.
- `TO_W`, default 10: width of the timeout counter; must hold `ACK_TIMEOUT`.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `done` in 1: one-cycle pulse from the vending core; the result fields below are valid in the same cycle.
- `ticket_out` in 2: destination code to print.
- `count` in 2: number of tickets, 0–3.
- `change` in 8: change amount, in units of 1.
- `refund` in 8: refund amount; nonzero means the transaction failed.
- `tkt_req` out 1: request to print one ticket.
- `tkt_dest` out 2: destination for the current ticket; stable while `tkt_req` is high.
- `tkt_ack` in 1: printer has accepted the ticket.
- `coin_req` out 1: request to eject one coin.
- `coin_code` out 3: coin to eject (1=1, 2=2, 3=5, 4=10, 5=20, 6=50; 0 when idle); stable while `coin_req` is high.
- `coin_ack` in 1: hopper has ejected the coin.
- `busy` out 1: high from the cycle after an accepted `done` until `fin`.
- `fin` out 1: one-cycle pulse when the job ends.
- `fault` out 1: sticky; set on ack timeout; cleared only by `rst` or the next accepted `done`.
- `overrun` out 1: one-cycle pulse when `done` arrives while `busy`.

## Operation
- FSM states: IDLE, TKT_REQ, TKT_GAP, COIN_REQ, COIN_GAP, FINISH.
- IDLE + `done`:
  - Latch `ticket_out`, `count`, `change`, `refund`. Clear `fault`.
  - If `refund` ≠ 0, the amount to pay is `refund` and the ticket count is forced to 0. Otherwise the amount is `change`.
  - Next state: TKT_REQ if tickets > 0; else COIN_REQ if amount > 0; else FINISH.
- TKT_REQ:
  - `tkt_req` = 1, `tkt_dest` = latched destination.
  - On `tkt_ack`: decrement the remaining-ticket counter and go to TKT_GAP.
- TKT_GAP: `tkt_req` = 0 for one cycle, then:
  - TKT_REQ if tickets remain;
  - else COIN_REQ if amount > 0;
  - else FINISH.
- COIN_REQ:
  - `coin_code` = largest denomination ≤ remaining amount, chosen from 50, 20, 10, 5, 2, 1.
  - On `coin_ack`: subtract that denomination (8-bit, never underflows) and go to COIN_GAP.
- COIN_GAP: one idle cycle, then COIN_REQ if the remainder is > 0, else FINISH.
- FINISH: `fin` = 1 for one cycle, then IDLE.
- Timeout:
  - The counter clears on entry to each REQ state and increments while waiting.
  - When it reaches `ACK_TIMEOUT` without an ack: drop the request, set `fault`, go to FINISH. Remaining items are abandoned.
- An ack arriving while the matching req is low is ignored.
- `done` while not in IDLE: the job is not disturbed; `overrun` pulses.
- `rst` (synchronous) at any point, including mid-handshake:
  - State goes to IDLE; all counters and latches clear.
  - All outputs go to 0 at the next edge: `tkt_req`, `tkt_dest`, `coin_req`, `coin_code`, `busy`, `fin`, `fault`, `overrun`.

## Timing
- `done` sampled at edge 0 → `tkt_req`/`coin_req` high and `busy` high after edge 1.
- `ack` sampled at edge k → req low after edge k+1. The next req is high after edge k+2, so there is a minimum 1-cycle low gap between items.
- With zero-wait acks (ack in the first req cycle), each item costs 2 cycles.
- `fin` is high in the cycle after the last GAP cycle (or after the timeout edge). `busy` falls together with `fin`.
- A job with no tickets and zero amount: `fin` is high after edge 1, and no req is ever raised.
- `done` in the same cycle as `fin` (state FINISH) is an overrun and is not accepted. `done` is accepted again from IDLE, the cycle after `fin`.

## Test plan
- `count`=3, `ticket_out`=2, `change`=0, `refund`=0, immediate acks → exactly 3 `tkt_req` handshakes with `tkt_dest`=2, no coins, `fin` 6 cycles after the first req.
- `count`=1, `change`=87 → 1 ticket, then `coin_code` sequence 6, 5, 4, 3, 2 (50+20+10+5+2), then `fin`; `fault`=0.
- `refund`=100, `count`=3 → no `tkt_req`; coins 6, 6; `fin`.
- `count`=2, `tkt_ack` withheld, `ACK_TIMEOUT`=8 → after 8 req cycles: `tkt_req` drops, `fault`=1, `fin` pulses. The next `done` clears `fault`.
- `done` pulsed again during coin payout → `overrun` pulses once; the original coin sequence completes unchanged; spurious `coin_ack` with `coin_req` low has no effect.
- `rst` asserted while `coin_req` is high → next cycle all outputs are 0 and state is IDLE; a following `count`=1 job completes normally.
